pad_column_scheduler: RTL
=========================

Name: pad_column_scheduler

Overview:
- Frame-level controller for the ping-pong input buffer and the PE column feed.
- On each ready frame (24x32 pixels, 8-bit) it flips the ping-pong select and walks the buffer column by column.
- It emits 34 padded columns of 26 bytes each (208 bits) to the PE array over a valid/ready handshake.
- Columns 0 and 33 are all-pad; every other column has one pad byte at each end.

Parameters:
- IMG_ROWS, 24, pixel rows per frame (valid pixels per column)
- IMG_COLS, 32, pixel columns per frame
- DW, 8, pixel width in bits
- ADDR_W, 10, buffer read address width; must satisfy 2^ADDR_W >= IMG_ROWS*IMG_COLS

Ports:
- clk  in  1  single clock; buffer output side and PE side
- rst  in  1  asynchronous, active-high reset
- en  in  1  advance enable; low stalls new reads and state advance
- buf_ready  in  1  level; a full frame is waiting in the ping-pong buffer
- pad_value  in  DW  padding byte
- switch_pingpong  out  1  one-cycle pulse at frame start
- rd_en  out  1  buffer read strobe
- rd_addr  out  ADDR_W  buffer read address
- rd_data  in  DW  buffer read data, valid exactly 1 cycle after rd_en
- col_data  out  (IMG_ROWS+2)*DW  padded column
- col_vld  out  1  col_data valid
- col_rdy  in  1  PE accepts the column
- col_idx  out  6  index of the presented column, 0..IMG_COLS+1
- frame_done  out  1  one-cycle pulse after column IMG_COLS+1 is accepted
- busy  out  1  high in every state except IDLE
- stall_cycles  out  16  see Optional Feature

Behaviour:
- Reset values: all outputs 0, state IDLE, internal row/column counters 0.
- States: IDLE, START, PADCOL, FETCH, EMIT, DONE.
- IDLE -> START when buf_ready && en.
- START (1 cycle):
  - switch_pingpong=1.
  - Latch pad_value into pad_q; it is held for the whole frame.
  - col_idx=0; go to PADCOL.
- PADCOL (1 cycle): every slot of col_data = pad_q; go to EMIT.
- FETCH:
  - Slots 0 and IMG_ROWS+1 = pad_q.
  - For r = 0..IMG_ROWS-1, one read per cycle while en: rd_en=1, rd_addr = r*IMG_COLS + (col_idx-1).
  - rd_data returned for row r goes to slot r+1.
  - Go to EMIT the cycle after the last data is captured: IMG_ROWS+1 cycles with en held high.
- Slot k occupies col_data[(IMG_ROWS+2-k)*DW-1 -: DW]. Slot 0 is the MSB byte.
- EMIT:
  - col_vld=1; col_data and col_idx stay stable until col_rdy.
  - On col_vld && col_rdy, col_vld drops the next cycle.
  - If col_idx==IMG_COLS+1, go to DONE.
  - Otherwise col_idx+1, then PADCOL if the new index is IMG_COLS+1, else FETCH.
- DONE (1 cycle): frame_done=1; go to IDLE. buf_ready is re-sampled only in IDLE.
- en low:
  - No new rd_en.
  - A read issued in the previous cycle is still captured.
  - No state advance, except EMIT: the handshake still completes.
- buf_ready dropping mid-frame is ignored.
- Reset mid-frame returns to IDLE immediately: col_vld=0, no switch pulse.
- Arithmetic: compute the address with ADDR_W-bit unsigned math; no wrap for legal parameters.
- Frame latency with en=1 and col_rdy=1: 1 + 2 + 32*(IMG_ROWS+2) + 2 + 1 cycles.

Optional Feature:
- Macro: COL_PERF_CNT_EN.
- Defined: stall_cycles counts cycles with col_vld && !col_rdy. It clears in START and saturates at 16'hFFFF.
- Undefined: stall_cycles is tied to 0 and no counter logic is built.

Decomposition:
- Shared package:
  - IMG_ROWS/IMG_COLS/DW defaults
  - COL_W = (IMG_ROWS+2)*DW
  - state enum encoding
  - LAST_COL = IMG_COLS+1
- Sub-module pad_col_assembler holds the slot register file and the pad/slot write logic (inputs: fill_all_pad, wr_slot, wr_data, pad). The FSM stays in the parent.

Test Plan:
- Pixel(r,c) = r*32+c (mod 256), pad_value=8'hAA, col_rdy=1 -> 34 columns emitted.
  - Col 0 and col 33 all 8'hAA.
  - Col 5: slot0=AA, slot1=8'h04, slot24=(23*32+4)%256=8'hE4, slot25=AA.
  - frame_done after col 33; one switch_pingpong pulse.
- col_rdy held low 10 cycles at col 3 -> col_data/col_idx=3 stable; with COL_PERF_CNT_EN, stall_cycles=10.
- en low for 5 cycles mid-FETCH after row 7 -> no rd_en during the gap; row 7 data lands in slot 8; column contents unchanged vs. the no-stall run.
- buf_ready held high across two frames -> second START only after DONE; exactly 2 switch pulses, 68 columns.
- rst pulsed during col 12 FETCH -> col_vld=0, busy=0 next cycle; new frame restarts at col_idx 0.
- pad_value changed mid-frame from AA to 55 -> all pad slots remain AA until the next START.

Source files
------------

// File: rtl/pad_column_scheduler_pkg.sv
// Shared defaults, derived widths and FSM encoding for the padded-column scheduler.
package pad_column_scheduler_pkg;

   localparam int DEF_IMG_ROWS = 24;
   localparam int DEF_IMG_COLS = 32;
   localparam int DEF_DW       = 8;
   localparam int DEF_ADDR_W   = 10;
   localparam int COL_W        = (DEF_IMG_ROWS + 2) * DEF_DW;
   localparam int LAST_COL     = DEF_IMG_COLS + 1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_PADCOL = 3'd2,
      ST_FETCH  = 3'd3,
      ST_EMIT   = 3'd4,
      ST_DONE   = 3'd5
   } state_e;

endpackage

// File: rtl/pad_column_scheduler_assembler.sv
// Slot register file for one padded column; slot 0 sits in the most significant byte.
module pad_col_assembler
   import pad_column_scheduler_pkg::*;
#(
   parameter int N_ROWS = DEF_IMG_ROWS,
   parameter int PIX_W  = DEF_DW,
   parameter int SLOT_W = 5
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          fill_all_pad,
   input  logic                          wr_en,
   input  logic [SLOT_W-1:0]             wr_slot,
   input  logic [PIX_W-1:0]              wr_data,
   input  logic [PIX_W-1:0]              pad,
   output logic [(N_ROWS+2)*PIX_W-1:0]   col_data
);

   logic [PIX_W-1:0] slot_r [N_ROWS+2];

   // Whole-column pad fill has priority over a single returned pixel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < N_ROWS + 2; k++) slot_r[k] <= {PIX_W{1'b0}};
      end else if (fill_all_pad) begin
         for (int k = 0; k < N_ROWS + 2; k++) slot_r[k] <= pad;
      end else if (wr_en) begin
         slot_r[wr_slot] <= wr_data;
      end
   end

   // Flatten slots into the column bus.
   always_comb begin
      col_data = {((N_ROWS+2)*PIX_W){1'b0}};
      for (int k = 0; k < N_ROWS + 2; k++)
         col_data[(N_ROWS+2-k)*PIX_W-1 -: PIX_W] = slot_r[k];
   end

endmodule

// File: rtl/pad_column_scheduler.sv
// Frame controller: flips the ping-pong buffer and streams IMG_COLS+2 padded columns to the PE array.
// Macro COL_PERF_CNT_EN builds the col_vld && !col_rdy stall counter; otherwise stall_cycles is 0.
module pad_column_scheduler
   import pad_column_scheduler_pkg::*;
#(
   parameter int IMG_ROWS = DEF_IMG_ROWS,
   parameter int IMG_COLS = DEF_IMG_COLS,
   parameter int DW       = DEF_DW,
   parameter int ADDR_W   = DEF_ADDR_W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic                        buf_ready,
   input  logic [DW-1:0]               pad_value,
   output logic                        switch_pingpong,
   output logic                        rd_en,
   output logic [ADDR_W-1:0]           rd_addr,
   input  logic [DW-1:0]               rd_data,
   output logic [(IMG_ROWS+2)*DW-1:0]  col_data,
   output logic                        col_vld,
   input  logic                        col_rdy,
   output logic [5:0]                  col_idx,
   output logic                        frame_done,
   output logic                        busy,
   output logic [15:0]                 stall_cycles
);

   localparam int               ROW_W    = $clog2(IMG_ROWS + 1);
   localparam int               SLOT_W   = $clog2(IMG_ROWS + 2);
   localparam logic [5:0]       LAST_IDX = 6'(IMG_COLS + 1);
   localparam logic [ROW_W-1:0] ROW_END  = ROW_W'(IMG_ROWS);

   state_e              state_r, state_nx_s;
   logic [ROW_W-1:0]    row_cnt_r;
   logic [5:0]          col_idx_r;
   logic [DW-1:0]       pad_q_r;
   logic                cap_vld_r;
   logic [SLOT_W-1:0]   cap_slot_r;
   logic                rd_en_s;
   logic [ADDR_W-1:0]   rd_addr_s;
   logic                sw_r, done_r, col_vld_r, busy_r;

   // Next-state logic; only EMIT may advance with en low so the handshake completes.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE:   if (buf_ready && en) state_nx_s = ST_START;  else state_nx_s = ST_IDLE;
         ST_START:  if (en) state_nx_s = ST_PADCOL;              else state_nx_s = ST_START;
         ST_PADCOL: if (en) state_nx_s = ST_EMIT;                else state_nx_s = ST_PADCOL;
         ST_FETCH:  if (en && row_cnt_r == ROW_END) state_nx_s = ST_EMIT;
                    else state_nx_s = ST_FETCH;
         ST_EMIT: begin
            if (!col_rdy)                          state_nx_s = ST_EMIT;
            else if (col_idx_r == LAST_IDX)        state_nx_s = ST_DONE;
            else if (col_idx_r + 6'd1 == LAST_IDX) state_nx_s = ST_PADCOL;
            else                                   state_nx_s = ST_FETCH;
         end
         ST_DONE:   if (en) state_nx_s = ST_IDLE;                else state_nx_s = ST_DONE;
         default:   state_nx_s = ST_IDLE;
      endcase
   end

   // Read strobe and address for the next row of the current buffer column.
   always_comb begin
      rd_en_s   = 1'b0;
      rd_addr_s = {ADDR_W{1'b0}};
      if (state_r == ST_FETCH && en && row_cnt_r != ROW_END) begin
         rd_en_s   = 1'b1;
         rd_addr_s = ADDR_W'(row_cnt_r) * ADDR_W'(IMG_COLS) + ADDR_W'(col_idx_r) - ADDR_W'(1);
      end else begin
         rd_en_s   = 1'b0;
         rd_addr_s = {ADDR_W{1'b0}};
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_r <= ST_IDLE;
      else     state_r <= state_nx_s;
   end

   // Column/row counters and the frame-wide pad byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_cnt_r <= {ROW_W{1'b0}};
         col_idx_r <= 6'd0;
         pad_q_r   <= {DW{1'b0}};
      end else begin
         if (state_r == ST_START) pad_q_r <= pad_value;
         if (state_r == ST_IDLE) begin
            col_idx_r <= 6'd0;
            row_cnt_r <= {ROW_W{1'b0}};
         end else if (state_r == ST_EMIT && col_rdy && col_idx_r != LAST_IDX) begin
            col_idx_r <= col_idx_r + 6'd1;
            row_cnt_r <= {ROW_W{1'b0}};
         end else if (rd_en_s) begin
            row_cnt_r <= row_cnt_r + ROW_W'(1);
         end
      end
   end

   // Track the in-flight read so its data lands even if en drops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_vld_r  <= 1'b0;
         cap_slot_r <= {SLOT_W{1'b0}};
      end else begin
         cap_vld_r  <= rd_en_s;
         cap_slot_r <= SLOT_W'(row_cnt_r) + SLOT_W'(1);
      end
   end

   // Registered status outputs; pulses fire on state entry only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_r      <= 1'b0;
         done_r    <= 1'b0;
         col_vld_r <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         sw_r      <= (state_r == ST_IDLE) && (state_nx_s == ST_START);
         done_r    <= (state_r != ST_DONE) && (state_nx_s == ST_DONE);
         col_vld_r <= (state_nx_s == ST_EMIT);
         busy_r    <= (state_nx_s != ST_IDLE);
      end
   end

   pad_col_assembler #(
      .N_ROWS (IMG_ROWS),
      .PIX_W  (DW),
      .SLOT_W (SLOT_W)
   ) u_asm (
      .clk          (clk),
      .rst          (rst),
      .fill_all_pad (state_r == ST_PADCOL),
      .wr_en        (cap_vld_r),
      .wr_slot      (cap_slot_r),
      .wr_data      (rd_data),
      .pad          (pad_q_r),
      .col_data     (col_data)
   );

`ifdef COL_PERF_CNT_EN
   logic [15:0] stall_cnt_r;

   // Saturating count of presented-but-refused column cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                          stall_cnt_r <= 16'd0;
      else if (state_r == ST_START)                     stall_cnt_r <= 16'd0;
      else if (col_vld_r && !col_rdy && stall_cnt_r != 16'hFFFF)
                                                        stall_cnt_r <= stall_cnt_r + 16'd1;
   end

   assign stall_cycles = stall_cnt_r;
`else
   assign stall_cycles = 16'd0;
`endif

   assign switch_pingpong = sw_r;
   assign frame_done      = done_r;
   assign col_vld         = col_vld_r;
   assign busy            = busy_r;
   assign col_idx         = col_idx_r;
   assign rd_en           = rd_en_s;
   assign rd_addr         = rd_addr_s;

endmodule
